// File: rtl/rst_seq_ctrl.sv
// ============================================================================
//  Module      : rst_seq_ctrl
//  Description : Reset sequencer: arbitrates reset requests, records the cause,
//                releases core reset then peripheral reset once the core reports
//                ready, and re-sequences on a ready timeout.
//                Optional macro RSTSEQ_CAUSE_LOG_EN adds a sticky cause log.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_seq_ctrl #(
    parameter int unsigned NUM_REQ       = 3,
    parameter int unsigned HOLD_CYCLES   = 4,
    parameter int unsigned READY_TIMEOUT = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               sys_ready_i,
    output logic               sys_rst_no,
    output logic               periph_rst_no,
    output logic [NUM_REQ:0]   cause_o,
    output logic               busy_o,
`ifdef RSTSEQ_CAUSE_LOG_EN
    input  logic               cause_clr_i,
    output logic [NUM_REQ:0]   cause_log_o,
`endif
    output logic               timeout_o
);

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > READY_TIMEOUT) ? HOLD_CYCLES : READY_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_rdy_last  = CNT_W'(READY_TIMEOUT - 1);
    localparam logic [NUM_REQ:0] c_cause_por = (NUM_REQ + 1)'(1);

    localparam logic [1:0] c_st_assert = 2'd0;
    localparam logic [1:0] c_st_wait   = 2'd1;
    localparam logic [1:0] c_st_active = 2'd2;

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sys_rst_n;
    logic               r_periph_rst_n;
    logic [NUM_REQ:0]   r_cause;
    logic               r_busy;
    logic               r_timeout;

    logic [NUM_REQ-1:0] w_req_lsb;
    logic [NUM_REQ:0]   w_req_cause;
    logic               w_req_evt;
    logic               w_hold_done;
    logic               w_rdy_done;

    // Two's-complement trick isolates the lowest set request bit (highest priority).
    always_comb begin
        w_req_lsb   = req_i & (~req_i + NUM_REQ'(1));
        w_req_cause = {w_req_lsb, 1'b0};
        w_req_evt   = (r_state == c_st_active) && (|req_i);
        w_hold_done = (r_cnt == c_hold_last);
        w_rdy_done  = (r_cnt == c_rdy_last);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= c_st_assert;
            r_cnt          <= '0;
            r_sys_rst_n    <= 1'b0;
            r_periph_rst_n <= 1'b0;
            r_cause        <= c_cause_por;
            r_busy         <= 1'b1;
            r_timeout      <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                c_st_assert: begin
                    if (w_hold_done) begin
                        r_cnt       <= '0;
                        r_sys_rst_n <= 1'b1;
                        r_state     <= c_st_wait;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                c_st_wait: begin
                    // Readiness wins even on the final allowed cycle.
                    if (sys_ready_i) begin
                        r_cnt          <= '0;
                        r_periph_rst_n <= 1'b1;
                        r_busy         <= 1'b0;
                        r_state        <= c_st_active;
                    end else if (w_rdy_done) begin
                        r_cnt       <= '0;
                        r_timeout   <= 1'b1;
                        r_sys_rst_n <= 1'b0;
                        r_cause     <= c_cause_por;
                        r_state     <= c_st_assert;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                c_st_active: begin
                    if (w_req_evt) begin
                        r_cnt          <= '0;
                        r_cause        <= w_req_cause;
                        r_sys_rst_n    <= 1'b0;
                        r_periph_rst_n <= 1'b0;
                        r_busy         <= 1'b1;
                        r_state        <= c_st_assert;
                    end
                end
                default: begin
                    r_cnt          <= '0;
                    r_sys_rst_n    <= 1'b0;
                    r_periph_rst_n <= 1'b0;
                    r_busy         <= 1'b1;
                    r_state        <= c_st_assert;
                end
            endcase
        end
    end

`ifdef RSTSEQ_CAUSE_LOG_EN
    logic [NUM_REQ:0] r_cause_log;
    logic [NUM_REQ:0] w_cause_evt;

    // Only freshly latched causes are logged, so a clear is not undone by a held cause_o.
    always_comb begin
        w_cause_evt = '0;
        if (w_req_evt) begin
            w_cause_evt = w_req_cause;
        end else if ((r_state == c_st_wait) && !sys_ready_i && w_rdy_done) begin
            w_cause_evt = c_cause_por;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cause_log <= c_cause_por;
        end else begin
            r_cause_log <= (cause_clr_i ? '0 : r_cause_log) | w_cause_evt;
        end
    end

    assign cause_log_o = r_cause_log;
`endif

    assign sys_rst_no    = r_sys_rst_n;
    assign periph_rst_no = r_periph_rst_n;
    assign cause_o       = r_cause;
    assign busy_o        = r_busy;
    assign timeout_o     = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_rst_seq_ctrl.sv
// ============================================================================
//  Module      : tb_rst_seq_ctrl
//  Description : Directed self-checking bench for rst_seq_ctrl (3 req, hold 4,
//                ready timeout 8). Covers RSTSEQ_CAUSE_LOG_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rst_seq_ctrl;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic       sys_ready;
    logic       sys_rst_n;
    logic       periph_rst_n;
    logic [3:0] cause;
    logic       busy;
    logic       timeout;
`ifdef RSTSEQ_CAUSE_LOG_EN
    logic       cause_clr;
    logic [3:0] cause_log;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    rst_seq_ctrl #(
        .NUM_REQ      (3),
        .HOLD_CYCLES  (4),
        .READY_TIMEOUT(8)
    ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .sys_ready_i  (sys_ready),
        .sys_rst_no   (sys_rst_n),
        .periph_rst_no(periph_rst_n),
        .cause_o      (cause),
        .busy_o       (busy),
`ifdef RSTSEQ_CAUSE_LOG_EN
        .cause_clr_i  (cause_clr),
        .cause_log_o  (cause_log),
`endif
        .timeout_o    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance one edge and sample 1 time unit later; the reset-ordering invariant is checked every cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        chk_eq("periph_before_core", 32'(periph_rst_n & ~sys_rst_n), 32'd0);
    endtask

    // From ASSERT entry with cnt=0 and sys_ready=1: core on edge 4, peripherals on edge 5.
    task automatic release_chk(input string tag);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_eq({tag, "_core_held"}, 32'(sys_rst_n), 32'd0);
        end
        tick();
        chk_eq({tag, "_core_rel"}, 32'(sys_rst_n), 32'd1);
        chk_eq({tag, "_periph_held"}, 32'(periph_rst_n), 32'd0);
        chk_eq({tag, "_busy_wait"}, 32'(busy), 32'd1);
        tick();
        chk_eq({tag, "_periph_rel"}, 32'(periph_rst_n), 32'd1);
        chk_eq({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic request(input logic [2:0] r, input logic [3:0] exp_cause, input string tag);
        req = r;
        tick();
        req = 3'b000;
        chk_eq({tag, "_core"}, 32'(sys_rst_n), 32'd0);
        chk_eq({tag, "_periph"}, 32'(periph_rst_n), 32'd0);
        chk_eq({tag, "_busy"}, 32'(busy), 32'd1);
        chk_eq({tag, "_cause"}, 32'(cause), 32'(exp_cause));
    endtask

    initial begin
        rst       = 1'b1;
        req       = 3'b000;
        sys_ready = 1'b1;
`ifdef RSTSEQ_CAUSE_LOG_EN
        cause_clr = 1'b0;
`endif
        // POR
        tick();
        tick();
        chk_eq("por_core", 32'(sys_rst_n), 32'd0);
        chk_eq("por_periph", 32'(periph_rst_n), 32'd0);
        chk_eq("por_cause", 32'(cause), 32'h1);
        chk_eq("por_busy", 32'(busy), 32'd1);
        chk_eq("por_timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        release_chk("por");
        chk_eq("por_cause_final", 32'(cause), 32'h1);

        // Single request
        request(3'b010, 4'b0100, "req1");
        release_chk("req1_rel");

        // Priority: req 1 beats req 2
        request(3'b110, 4'b0100, "prio");
        release_chk("prio_rel");

        // Held request restarts a sequence right after reaching ACTIVE
        req = 3'b001;
        tick();
        chk_eq("held_cause", 32'(cause), 32'b0010);
        for (int i = 0; i < 4; i++) tick();
        chk_eq("held_core_rel", 32'(sys_rst_n), 32'd1);
        tick();
        chk_eq("held_active", 32'(periph_rst_n), 32'd1);
        tick();
        req = 3'b000;
        chk_eq("held_retrig_periph", 32'(periph_rst_n), 32'd0);
        chk_eq("held_retrig_busy", 32'(busy), 32'd1);
        release_chk("held_rel");

        // Ready timeout
        request(3'b100, 4'b1000, "to_req");
        sys_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk_eq("to_core_rel", 32'(sys_rst_n), 32'd1);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk_eq("to_waiting", 32'(timeout), 32'd0);
        end
        tick();
        chk_eq("to_pulse", 32'(timeout), 32'd1);
        chk_eq("to_core", 32'(sys_rst_n), 32'd0);
        chk_eq("to_periph", 32'(periph_rst_n), 32'd0);
        chk_eq("to_cause", 32'(cause), 32'h1);
        chk_eq("to_busy", 32'(busy), 32'd1);
        sys_ready = 1'b1;
        tick();
        chk_eq("to_pulse_end", 32'(timeout), 32'd0);
        for (int i = 0; i < 2; i++) tick();
        chk_eq("to_reseq_held", 32'(sys_rst_n), 32'd0);
        tick();
        chk_eq("to_reseq_core", 32'(sys_rst_n), 32'd1);
        tick();
        chk_eq("to_reseq_periph", 32'(periph_rst_n), 32'd1);

        // Ready on the final allowed cycle beats the timeout
        request(3'b001, 4'b0010, "late");
        sys_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 7; i++) tick();
        sys_ready = 1'b1;
        tick();
        chk_eq("late_no_timeout", 32'(timeout), 32'd0);
        chk_eq("late_periph", 32'(periph_rst_n), 32'd1);
        chk_eq("late_cause", 32'(cause), 32'b0010);

        // Mid-sequence reset in ASSERT cycle 2
        request(3'b010, 4'b0100, "mid");
        tick();
        rst = 1'b1;
        tick();
        chk_eq("mid_core", 32'(sys_rst_n), 32'd0);
        chk_eq("mid_cause", 32'(cause), 32'h1);
        chk_eq("mid_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        release_chk("mid_rel");

`ifdef RSTSEQ_CAUSE_LOG_EN
        chk_eq("log_por", 32'(cause_log), 32'b0001);
        request(3'b001, 4'b0010, "log_r0");
        chk_eq("log_r0", 32'(cause_log), 32'b0011);
        release_chk("log_r0_rel");
        request(3'b100, 4'b1000, "log_r2");
        chk_eq("log_r2", 32'(cause_log), 32'b1011);
        release_chk("log_r2_rel");
        cause_clr = 1'b1;
        tick();
        cause_clr = 1'b0;
        chk_eq("log_clr", 32'(cause_log), 32'b0000);
        tick();
        chk_eq("log_clr_stays", 32'(cause_log), 32'b0000);
        cause_clr = 1'b1;
        request(3'b010, 4'b0100, "log_r1");
        cause_clr = 1'b0;
        chk_eq("log_set_wins", 32'(cause_log), 32'b0100);
        release_chk("log_r1_rel");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
